gpgpu_conf_regs_slave: RTL and testbench
========================================

GPGPU_CONF_REGS_SLAVE -- requirements
Module: gpgpu_conf_regs_slave

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, reset value of KERNEL_PC.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, the reset; asynchronous and active-high.
REQ-004 SHALL have port req_i, input, 1, OBI request valid.
REQ-005 SHALL have port we_i, input, 1, OBI write enable (1 = write).
REQ-006 SHALL have port be_i, input, 4, OBI byte enables.
REQ-007 SHALL have port addr_i, input, 32, OBI byte address; only addr_i[4:2] decoded.
REQ-008 SHALL have port wdata_i, input, 32, OBI write data.
REQ-009 SHALL have port gnt_o, output, 1, OBI grant.
REQ-010 SHALL have port rvalid_o, output, 1, OBI response valid.
REQ-011 SHALL have port rdata_o, output, 32, OBI read data.
REQ-012 SHALL have port start_o, output, 1, one-cycle kernel launch pulse to the GPGPU core.
REQ-013 SHALL have port kernel_pc_o, output, 32, current KERNEL_PC value.
REQ-014 SHALL have port done_i, input, 1, one-cycle kernel completion pulse from the core.

Function
REQ-015 SHALL drive gnt_o = req_i combinationally; the responder never stalls.
REQ-016 SHALL assert rvalid_o for exactly one cycle, the cycle after each granted request, for reads and writes alike.
REQ-017 SHALL accept back-to-back requests, one per cycle, with one response per grant in order.
REQ-018 SHALL register rdata_o with the read value sampled at grant; rdata_o = 0 on write responses.
REQ-019 SHALL map addr_i[4:2]: 0 CTRL, 1 START, 2 STATUS, 3 KERNEL_PC, 4 CYCLE_CNT; 5-7 unmapped.
REQ-020 CTRL SHALL be RW; bit0 = enable; bits 31:1 read 0.
REQ-021 START SHALL read 0; a write with be_i[0]=1 and wdata_i[0]=1 is a start request.
REQ-022 STATUS SHALL read {30'b0, done, busy}; busy is read-only; done is sticky, cleared by write-1 to bit1 with be_i[0]=1.
REQ-023 KERNEL_PC SHALL be RW, honouring be_i per byte.
REQ-024 CYCLE_CNT SHALL be read-only, 32 bits, counting cycles while busy, saturating at 32'hFFFF_FFFF.
REQ-025 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored without error.
REQ-026 SHALL implement FSM IDLE/RUN: IDLE->RUN on start request when CTRL.enable=1; RUN->IDLE on done_i.
REQ-027 On IDLE->RUN, start_o SHALL pulse high in the cycle after the grant, CYCLE_CNT SHALL clear to 0, done SHALL clear.
REQ-028 start requests in RUN or with enable=0 SHALL be ignored (no pulse, no state change).
REQ-029 On RUN->IDLE, done SHALL set; busy = (state == RUN).
REQ-030 done_i in IDLE SHALL be ignored.
REQ-031 Simultaneous done set and W1C in the same cycle: set SHALL win.
REQ-032 Writes to KERNEL_PC during RUN SHALL take effect; kernel_pc_o follows immediately.

Reset
REQ-033 While rst_i=1: gnt_o follows req_i, rvalid_o=0, rdata_o=0, start_o=0, FSM=IDLE, CTRL=0, done=0, CYCLE_CNT=0, KERNEL_PC=RESET_PC; requests during reset produce no response.
REQ-034 Reset asserted mid-RUN SHALL abort to IDLE with no done set and no pending rvalid_o after release.

Verification
REQ-035 Write CTRL=1, read CTRL -> rvalid_o one cycle after each grant, rdata_o=32'h1.
REQ-036 CTRL=1, write START=1 -> start_o high one cycle, STATUS reads 32'h1; after 10 cycles CYCLE_CNT reads 10 (+/-1 for read latency, fixed by bench); done_i pulse -> STATUS reads 32'h2.
REQ-037 CTRL=0, write START=1 -> no start_o, STATUS reads 0; second START while busy -> no pulse.
REQ-038 KERNEL_PC=0, write 32'hAABBCCDD with be_i=4'b0101 -> reads 32'h00BB00DD; unmapped addr 0x18 read -> 0.
REQ-039 Back-to-back read CTRL, write KERNEL_PC, read KERNEL_PC on consecutive cycles -> three consecutive rvalid_o, correct in-order data.
REQ-040 Assert rst_i mid-RUN -> outputs reset values, STATUS reads 0 after release.

Source files
------------

// File: rtl/gpgpu_conf_regs_slave.sv
// OBI configuration slave for the GPGPU: CTRL/START/STATUS/KERNEL_PC/CYCLE_CNT registers and IDLE/RUN launch FSM.
// Response one cycle after grant; gnt follows req combinationally, so the slave never applies backpressure.
module gpgpu_conf_regs_slave #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        start_o,
   output logic [31:0] kernel_pc_o,
   input  logic        done_i
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state;
   logic        ctrl_en;
   logic        done;
   logic [31:0] kernel_pc;
   logic [31:0] cycle_cnt;
   logic [31:0] rd_val;
   logic [2:0]  reg_sel;
   logic        wr;
   logic        busy;
   logic        start_req;
   logic        launch;
   logic        w1c;
   logic        unused_addr;

   assign reg_sel     = addr_i[4:2];
   assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};
   assign wr          = req_i & we_i;
   assign busy        = (state == RUN);
   assign gnt_o       = req_i;
   assign kernel_pc_o = kernel_pc;

   assign start_req = wr && (reg_sel == 3'd1) && be_i[0] && wdata_i[0];
   assign launch    = start_req && ctrl_en && (state == IDLE);
   assign w1c       = wr && (reg_sel == 3'd2) && be_i[0] && wdata_i[1];

   always_comb begin
      rd_val = 32'h0;
      case (reg_sel)
         3'd0:    rd_val = {31'b0, ctrl_en};
         3'd2:    rd_val = {30'b0, done, busy};
         3'd3:    rd_val = kernel_pc;
         3'd4:    rd_val = cycle_cnt;
         default: rd_val = 32'h0;
      endcase
   end

   // Bus response path: every grant yields exactly one response next cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rvalid_o <= 1'b0;
         rdata_o  <= 32'h0;
      end else begin
         rvalid_o <= req_i;
         rdata_o  <= (req_i && !we_i) ? rd_val : 32'h0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_en   <= 1'b0;
         kernel_pc <= RESET_PC;
      end else begin
         if (wr && (reg_sel == 3'd0) && be_i[0])
            ctrl_en <= wdata_i[0];
         if (wr && (reg_sel == 3'd3)) begin
            for (int b = 0; b < 4; b++)
               if (be_i[b]) kernel_pc[8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Launch FSM; done set only happens in RUN and launch only in IDLE, so they never collide.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         start_o   <= 1'b0;
         done      <= 1'b0;
         cycle_cnt <= 32'h0;
      end else begin
         start_o <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  state     <= RUN;
                  start_o   <= 1'b1;
                  cycle_cnt <= 32'h0;
                  done      <= 1'b0;
               end else if (w1c) begin
                  done <= 1'b0;
               end
            end
            RUN: begin
               if (cycle_cnt != 32'hFFFF_FFFF)
                  cycle_cnt <= cycle_cnt + 32'd1;
               if (done_i) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end else if (w1c) begin
                  done <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpgpu_conf_regs_slave.sv
// Directed bench for gpgpu_conf_regs_slave: register access, launch FSM, cycle counter, reset abort.
module tb_gpgpu_conf_regs_slave;

   localparam logic [31:0] RPC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        start;
   logic [31:0] kernel_pc;
   logic        done_in;

   int checks = 0;
   int errors = 0;

   logic        rv_s;
   logic [31:0] rd_s;

   gpgpu_conf_regs_slave #(.RESET_PC(RPC)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .we_i        (we),
      .be_i        (be),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .gnt_o       (gnt),
      .rvalid_o    (rvalid),
      .rdata_o     (rdata),
      .start_o     (start),
      .kernel_pc_o (kernel_pc),
      .done_i      (done_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One transaction: grant on the next rising edge, response sampled 1ns later.
   task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(posedge clk);
      #1;
      req = 1'b0; we = 1'b0;
      rv_s = rvalid;
      rd_s = rdata;
   endtask

   task automatic pulse_done();
      @(negedge clk);
      done_in = 1'b1;
      @(posedge clk);
      #1;
      done_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0; done_in = 1'b0;
      rv_s = 1'b0; rd_s = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_start", {31'b0, start}, 32'h0);
      chk("rst_kpc", kernel_pc, RPC);
      @(negedge clk);
      rst = 1'b0;

      // CTRL write then read
      bus(1'b1, 32'h0, 32'h1, 4'hF);
      chk("ctrl_wr_rvalid", {31'b0, rv_s}, 32'h1);
      chk("ctrl_wr_rdata", rd_s, 32'h0);
      bus(1'b0, 32'h0, 32'h0, 4'hF);
      chk("ctrl_rd_rvalid", {31'b0, rv_s}, 32'h1);
      chk("ctrl_rd", rd_s, 32'h1);
      @(posedge clk); #1;
      chk("rvalid_idle", {31'b0, rvalid}, 32'h0);

      // done_i while IDLE is ignored
      pulse_done();
      bus(1'b0, 32'h8, 32'h0, 4'hF);
      chk("idle_done_status", rd_s, 32'h0);

      // Launch and count
      bus(1'b1, 32'h4, 32'h1, 4'h1);
      chk("start_pulse", {31'b0, start}, 32'h1);
      bus(1'b0, 32'h8, 32'h0, 4'hF);
      chk("status_busy", rd_s, 32'h1);
      chk("start_one_cycle", {31'b0, start}, 32'h0);
      repeat (9) @(posedge clk);
      bus(1'b0, 32'h10, 32'h0, 4'hF);
      chk("cycle_cnt_10", rd_s, 32'd10);
      bus(1'b1, 32'h4, 32'h1, 4'h1);
      chk("start_while_busy", {31'b0, start}, 32'h0);
      pulse_done();
      bus(1'b0, 32'h8, 32'h0, 4'hF);
      chk("status_done", rd_s, 32'h2);
      bus(1'b1, 32'h8, 32'h2, 4'h1);
      bus(1'b0, 32'h8, 32'h0, 4'hF);
      chk("status_w1c", rd_s, 32'h0);

      // Start with enable=0 is ignored
      bus(1'b1, 32'h0, 32'h0, 4'hF);
      bus(1'b1, 32'h4, 32'h1, 4'h1);
      chk("start_disabled", {31'b0, start}, 32'h0);
      bus(1'b0, 32'h8, 32'h0, 4'hF);
      chk("status_disabled", rd_s, 32'h0);

      // Byte enables and unmapped read
      bus(1'b1, 32'hC, 32'h0, 4'hF);
      bus(1'b1, 32'hC, 32'hAABBCCDD, 4'b0101);
      chk("kpc_out_be", kernel_pc, 32'h00BB00DD);
      bus(1'b0, 32'hC, 32'h0, 4'hF);
      chk("kpc_rd_be", rd_s, 32'h00BB00DD);
      bus(1'b1, 32'h18, 32'hFFFFFFFF, 4'hF);
      bus(1'b0, 32'h18, 32'h0, 4'hF);
      chk("unmapped_rd", rd_s, 32'h0);

      // Back-to-back: CTRL read, KPC write, KPC read
      bus(1'b1, 32'h0, 32'h1, 4'h1);
      bus(1'b0, 32'h0, 32'h0, 4'hF);
      chk("b2b0_rvalid", {31'b0, rv_s}, 32'h1);
      chk("b2b0_data", rd_s, 32'h1);
      bus(1'b1, 32'hC, 32'h12345678, 4'hF);
      chk("b2b1_rvalid", {31'b0, rv_s}, 32'h1);
      chk("b2b1_data", rd_s, 32'h0);
      bus(1'b0, 32'hC, 32'h0, 4'hF);
      chk("b2b2_rvalid", {31'b0, rv_s}, 32'h1);
      chk("b2b2_data", rd_s, 32'h12345678);

      // Reset in the middle of a run, with a request pending
      bus(1'b1, 32'h4, 32'h1, 4'h1);
      chk("run2_start", {31'b0, start}, 32'h1);
      bus(1'b1, 32'hC, 32'hDEADBEEF, 4'hF);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h8;
      rst = 1'b1;
      #1;
      chk("rst_gnt_follows_req", {31'b0, gnt}, 32'h1);
      @(posedge clk); #1;
      chk("midrst_rvalid", {31'b0, rvalid}, 32'h0);
      chk("midrst_start", {31'b0, start}, 32'h0);
      chk("midrst_kpc", kernel_pc, RPC);
      @(negedge clk);
      req = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_rvalid", {31'b0, rvalid}, 32'h0);
      bus(1'b0, 32'h8, 32'h0, 4'hF);
      chk("post_rst_status", rd_s, 32'h0);
      bus(1'b0, 32'h0, 32'h0, 4'hF);
      chk("post_rst_ctrl", rd_s, 32'h0);
      bus(1'b0, 32'h10, 32'h0, 4'hF);
      chk("post_rst_cnt", rd_s, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
